regfile_scoreboard: RTL and testbench

Parametrised, clocked general-purpose register file for the single-cycle/multicycle CPU datapath, replacing the memory-file-backed register block. It provides two combinational read ports and one synchronous write port, with write-through bypass and a byte-write mode. A per-register busy scoreboard lets the control unit detect reads of registers whose pending write has not yet retired. The block sits between the decode stage (reads, reservations) and the writeback stage (writes).

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port with
// write-through bypass and byte-write mode, and a per-register busy scoreboard.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              byteOperations,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_reg,
    output logic              any_busy
);

    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);
    localparam logic              HAS_ZERO  = (ZERO_REG != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_en;
    logic                rsv_en;
    logic [DATA_W-1:0]   merged;

    // Effective write/reserve enables and the value a write would commit
    always_comb begin
        wr_en  = regWrite & ~reset & ~(HAS_ZERO & (write_reg == '0));
        rsv_en = reserve_en & ~reset & ~(HAS_ZERO & (reserve_reg == '0));
        if (byteOperations) begin
            merged = (regs[write_reg] & ~BYTE_MASK) | (write_data & BYTE_MASK);
        end else begin
            merged = write_data;
        end
    end

    // Read port 1 with bypass of the in-flight write
    always_comb begin
        read_data1 = regs[read_reg1];
        busy1      = busy[read_reg1];
        if (wr_en && (write_reg == read_reg1)) begin
            read_data1 = merged;
            busy1      = 1'b0;
        end
        if (HAS_ZERO && (read_reg1 == '0)) begin
            read_data1 = '0;
            busy1      = 1'b0;
        end
    end

    // Read port 2 with bypass of the in-flight write
    always_comb begin
        read_data2 = regs[read_reg2];
        busy2      = busy[read_reg2];
        if (wr_en && (write_reg == read_reg2)) begin
            read_data2 = merged;
            busy2      = 1'b0;
        end
        if (HAS_ZERO && (read_reg2 == '0)) begin
            read_data2 = '0;
            busy2      = 1'b0;
        end
    end

    // Aggregate scoreboard view from stored bits only
    always_comb begin
        any_busy = |busy;
    end

    // Storage and scoreboard update; a same-edge reservation beats the retire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_en) begin
                regs[write_reg] <= merged;
                busy[write_reg] <= 1'b0;
            end
            if (rsv_en) begin
                busy[reserve_reg] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array model;
// a second instance covers the DATA_W=16 / NUM_REGS=8 / ZERO_REG=0 corner.
module tb_regfile_scoreboard;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg, reserve_reg;
    logic [31:0] write_data;
    logic        regWrite, byteOperations, reserve_en;
    logic [31:0] read_data1, read_data2;
    logic        busy1, busy2, any_busy;
    logic [15:0] s_rd1, s_rd2;
    logic        s_busy1, s_busy2, s_any;

    int checks;
    int errors;

    // Model state: index 0 = main instance, 1 = small instance
    logic [31:0] mr [2][32];
    logic        mb [2][32];

    regfile_scoreboard dut (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .busy1(busy1), .busy2(busy2),
        .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data),
        .byteOperations(byteOperations),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg),
        .any_busy(any_busy)
    );

    regfile_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .ZERO_REG(0)) dut16 (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1[2:0]), .read_reg2(read_reg2[2:0]),
        .read_data1(s_rd1), .read_data2(s_rd2),
        .busy1(s_busy1), .busy2(s_busy2),
        .regWrite(regWrite), .write_reg(write_reg[2:0]), .write_data(write_data[15:0]),
        .byteOperations(byteOperations),
        .reserve_en(reserve_en), .reserve_reg(reserve_reg[2:0]),
        .any_busy(s_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int amask(int k);
        return (k == 0) ? 31 : 7;
    endfunction

    function automatic logic [31:0] dmask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic bit zr(int k);
        return (k == 0);
    endfunction

    function automatic bit m_wok(int k);
        int wa;
        wa = int'(write_reg) & amask(k);
        return regWrite && !reset && !(zr(k) && wa == 0);
    endfunction

    function automatic logic [31:0] m_merged(int k);
        int wa;
        logic [31:0] v;
        wa = int'(write_reg) & amask(k);
        if (byteOperations) v = (mr[k][wa] & ~32'hFF) | (write_data & 32'hFF);
        else                v = write_data;
        return v & dmask(k);
    endfunction

    function automatic logic [31:0] m_read(int k, logic [4:0] addr);
        int a;
        a = int'(addr) & amask(k);
        if (reset) return 32'h0;
        if (zr(k) && a == 0) return 32'h0;
        if (m_wok(k) && (int'(write_reg) & amask(k)) == a) return m_merged(k);
        return mr[k][a];
    endfunction

    function automatic logic m_busy(int k, logic [4:0] addr);
        int a;
        a = int'(addr) & amask(k);
        if (reset) return 1'b0;
        if (m_wok(k) && (int'(write_reg) & amask(k)) == a) return 1'b0;
        return mb[k][a];
    endfunction

    function automatic logic m_any(int k);
        logic r;
        r = 1'b0;
        if (reset) return 1'b0;
        for (int i = 0; i <= amask(k); i++) r = r | mb[k][i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every edge, reset wins over writes and reservations
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    mr[k][i] = 32'h0;
                    mb[k][i] = 1'b0;
                end
            end else begin
                if (m_wok(k)) begin
                    mr[k][int'(write_reg) & amask(k)] = m_merged(k);
                    mb[k][int'(write_reg) & amask(k)] = 1'b0;
                end
                if (reserve_en && !(zr(k) && (int'(reserve_reg) & amask(k)) == 0))
                    mb[k][int'(reserve_reg) & amask(k)] = 1'b1;
            end
        end
    end

    // Compare process: outputs checked mid-cycle against the model
    always @(negedge clk) begin
        chk("rd1",   read_data1,          m_read(0, read_reg1));
        chk("rd2",   read_data2,          m_read(0, read_reg2));
        chk("busy1", 32'(busy1),          32'(m_busy(0, read_reg1)));
        chk("busy2", 32'(busy2),          32'(m_busy(0, read_reg2)));
        chk("any",   32'(any_busy),       32'(m_any(0)));
        chk("s_rd1", 32'(s_rd1),          m_read(1, read_reg1));
        chk("s_rd2", 32'(s_rd2),          m_read(1, read_reg2));
        chk("s_busy1", 32'(s_busy1),      32'(m_busy(1, read_reg1)));
        chk("s_busy2", 32'(s_busy2),      32'(m_busy(1, read_reg2)));
        chk("s_any", 32'(s_any),          32'(m_any(1)));
    end

    // Apply one cycle of inputs, return mid-cycle before the committing edge
    task automatic drive(input logic rs, input logic rw, input logic [4:0] wa,
                         input logic [31:0] wd, input logic bo, input logic re,
                         input logic [4:0] ra, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk);
        #1;
        reset = rs; regWrite = rw; write_reg = wa; write_data = wd;
        byteOperations = bo; reserve_en = re; reserve_reg = ra;
        read_reg1 = a1; read_reg2 = a2;
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; regWrite = 1'b0; write_reg = '0; write_data = '0;
        byteOperations = 1'b0; reserve_en = 1'b0; reserve_reg = '0;
        read_reg1 = '0; read_reg2 = '0;
        repeat (3) @(posedge clk);

        // Reset state across every address
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            chk("reset_rd1", read_data1, 32'h0);
            chk("reset_rd2", read_data2, 32'h0);
            chk("reset_busy1", 32'(busy1), 32'h0);
            chk("reset_any", 32'(any_busy), 32'h0);
        end

        // Reset asserted mid-write discards the write
        drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        chk("bypass_r5", read_data1, 32'hDEADBEEF);
        reset = 1'b1;
        #1;
        chk("reset_mid_rd1", read_data1, 32'h0);
        drive(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 5, 5);
        chk("r5_after_reset", read_data1, 32'h0);

        // Full write then byte write with bypass
        drive(0, 1, 3, 32'h12345678, 0, 0, 0, 3, 3);
        chk("r3_bypass", read_data1, 32'h12345678);
        chk("r3_bypass_p2", read_data2, 32'h12345678);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("r3_stored", read_data1, 32'h12345678);
        drive(0, 1, 3, 32'h000000AB, 1, 0, 0, 3, 0);
        chk("r3_byte_bypass", read_data1, 32'h123456AB);
        drive(0, 0, 0, 0, 0, 0, 0, 3, 0);
        chk("r3_byte_stored", read_data1, 32'h123456AB);

        // Zero register ignores writes and reservations
        drive(0, 1, 0, 32'hFFFFFFFF, 0, 1, 0, 0, 0);
        chk("r0_wr_rd1", read_data1, 32'h0);
        chk("r0_wr_busy1", 32'(busy1), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_after_rd1", read_data1, 32'h0);
        chk("r0_after_busy1", 32'(busy1), 32'h0);
        chk("r0_after_any", 32'(any_busy), 32'h0);

        // Reserve, then retire with a write
        drive(0, 0, 0, 0, 0, 1, 7, 0, 7);
        chk("r7_rsv_same_cycle", 32'(busy2), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
        chk("r7_busy2", 32'(busy2), 32'h1);
        chk("r7_any", 32'(any_busy), 32'h1);
        drive(0, 1, 7, 32'h55, 0, 0, 0, 0, 7);
        chk("r7_retire_busy2", 32'(busy2), 32'h0);
        chk("r7_retire_rd2", read_data2, 32'h55);
        chk("r7_retire_any", 32'(any_busy), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 7);
        chk("r7_any_clear", 32'(any_busy), 32'h0);

        // Same-edge reserve and write: new producer wins
        drive(0, 1, 9, 32'hA5A5A5A5, 0, 1, 9, 9, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("r9_rd1", read_data1, 32'hA5A5A5A5);
        chk("r9_busy1", 32'(busy1), 32'h1);
        drive(0, 1, 9, 32'h1, 0, 0, 0, 9, 0);
        chk("r9_retire_busy1", 32'(busy1), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 9, 0);
        chk("r9_cleared", 32'(busy1), 32'h0);
        chk("r9_any", 32'(any_busy), 32'h0);

        // Small instance: r0 is an ordinary register
        drive(0, 1, 0, 32'h0000BEEF, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s_r0_stored", 32'(s_rd1), 32'h0000BEEF);
        drive(0, 1, 0, 32'h00000012, 1, 0, 0, 0, 0);
        chk("s_r0_byte_bypass", 32'(s_rd1), 32'h0000BE12);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("s_r0_byte_stored", 32'(s_rd1), 32'h0000BE12);

        // Random traffic with clustered addresses and occasional reset
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wa, ra, a1, a2;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 11));
            a2 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom);
            drive(1'($urandom_range(0, 199) == 0), 1'($urandom), wa, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom), ra, a1, a2);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
